// File: rtl/lcd_pkg.sv
// Shared LCD definitions used by the reader and the writer: FSM states, default
// phase timing, poll limit and the busy-flag bit position.
package lcd_pkg;

    typedef enum logic [3:0] {
        ST_IDLE, ST_SETUP_H, ST_EHIGH_H, ST_HOLD_H, ST_GAP,
        ST_SETUP_L, ST_EHIGH_L, ST_HOLD_L, ST_DONE
    } lcd_state_e;

    localparam int LCD_T_SETUP  = 2;
    localparam int LCD_T_EHIGH  = 12;
    localparam int LCD_T_HOLD   = 1;
    localparam int LCD_T_GAP    = 50;
    localparam int LCD_POLL_MAX = 1000;
    localparam int LCD_BUSY_BIT = 7;
    localparam int LCD_CNT_W    = 16;

endpackage

// File: rtl/lcd_delay_cnt.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module lcd_delay_cnt #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_reader.sv
// 4-bit LCD read sequencer: two E strobes per byte, upper nibble first.
// Optional busy-flag polling is enabled with LCD_READER_BUSY_POLL_EN.
module lcd_reader
    import lcd_pkg::*;
#(
    parameter int T_SETUP  = LCD_T_SETUP,
    parameter int T_EHIGH  = LCD_T_EHIGH,
    parameter int T_HOLD   = LCD_T_HOLD,
    parameter int T_GAP    = LCD_T_GAP
`ifdef LCD_READER_BUSY_POLL_EN
   ,parameter int POLL_MAX = LCD_POLL_MAX
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       rs_sel,
    input  logic [3:0] sf_d_in,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic       bus_own,
    output logic       busy,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       timeout
);

    localparam int W = LCD_CNT_W;

    lcd_state_e   state_q, state_d;
    logic         cnt_load, cnt_zero;
    logic [W-1:0] cnt_val;
    logic         rs_q;
    logic [3:0]   hi_q, lo_q;
    logic [7:0]   rd_q;

`ifdef LCD_READER_BUSY_POLL_EN
    logic         repoll_q, repoll_d, timeout_q, timeout_d;
    logic [W-1:0] poll_cnt_q, poll_cnt_d;
`endif

    lcd_delay_cnt #(.W(W)) u_dly (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .zero_o     (cnt_zero)
    );

    // Every transition reloads the counter with the new phase length minus one.
    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
`ifdef LCD_READER_BUSY_POLL_EN
        repoll_d   = repoll_q;
        poll_cnt_d = poll_cnt_q;
        timeout_d  = timeout_q;
`endif
        case (state_q)
            ST_IDLE: if (req) begin
                state_d = ST_SETUP_H; cnt_load = 1'b1; cnt_val = W'(T_SETUP - 1);
`ifdef LCD_READER_BUSY_POLL_EN
                repoll_d = 1'b0; poll_cnt_d = '0; timeout_d = 1'b0;
`endif
            end
            ST_SETUP_H: if (cnt_zero) begin
                state_d = ST_EHIGH_H; cnt_load = 1'b1; cnt_val = W'(T_EHIGH - 1);
            end
            ST_EHIGH_H: if (cnt_zero) begin
                state_d = ST_HOLD_H; cnt_load = 1'b1; cnt_val = W'(T_HOLD - 1);
            end
            ST_HOLD_H: if (cnt_zero) begin
                state_d = ST_GAP; cnt_load = 1'b1; cnt_val = W'(T_GAP - 1);
            end
            ST_GAP: if (cnt_zero) begin
                state_d = ST_SETUP_L; cnt_load = 1'b1; cnt_val = W'(T_SETUP - 1);
`ifdef LCD_READER_BUSY_POLL_EN
                if (repoll_q) begin
                    state_d = ST_SETUP_H; repoll_d = 1'b0;
                end
`endif
            end
            ST_SETUP_L: if (cnt_zero) begin
                state_d = ST_EHIGH_L; cnt_load = 1'b1; cnt_val = W'(T_EHIGH - 1);
            end
            ST_EHIGH_L: if (cnt_zero) begin
                state_d = ST_HOLD_L; cnt_load = 1'b1; cnt_val = W'(T_HOLD - 1);
            end
            ST_HOLD_L: if (cnt_zero) begin
                state_d = ST_DONE;
`ifdef LCD_READER_BUSY_POLL_EN
                poll_cnt_d = poll_cnt_q + 1'b1;
                if (!rs_q && hi_q[LCD_BUSY_BIT-4]) begin
                    if (poll_cnt_d >= W'(POLL_MAX)) begin
                        timeout_d = 1'b1;
                    end else begin
                        state_d = ST_GAP; cnt_load = 1'b1; cnt_val = W'(T_GAP - 1);
                        repoll_d = 1'b1;
                    end
                end
`endif
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rs_q <= 1'b0;
            hi_q <= '0;
            lo_q <= '0;
            rd_q <= '0;
        end else begin
            if (state_q == ST_IDLE && req)      rs_q <= rs_sel;
            if (state_q == ST_EHIGH_H && cnt_zero) hi_q <= sf_d_in;
            if (state_q == ST_EHIGH_L && cnt_zero) lo_q <= sf_d_in;
            // Publish only on entry to DONE so rd_data is stable between reads.
            if (state_q == ST_HOLD_L && state_d == ST_DONE) rd_q <= {hi_q, lo_q};
        end
    end

`ifdef LCD_READER_BUSY_POLL_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            repoll_q   <= 1'b0;
            poll_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            repoll_q   <= repoll_d;
            poll_cnt_q <= poll_cnt_d;
            timeout_q  <= timeout_d;
        end
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        lcd_e   = (state_q == ST_EHIGH_H) || (state_q == ST_EHIGH_L);
        lcd_rw  = (state_q != ST_IDLE) && (state_q != ST_DONE);
        bus_own = lcd_rw;
        busy    = (state_q != ST_IDLE);
        done    = (state_q == ST_DONE);
        lcd_rs  = rs_q;
        rd_data = rd_q;
    end

endmodule
